// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Two-requester arbiter in front of a single data memory port. One
// transaction is in flight at a time. Requesters are served round-robin and
// the memory handshake is driven by mem_clk_stall: a command strobe is issued
// for one cycle, the memory raises mem_clk_stall while busy, and its falling
// edge marks the data as ready. If the memory never responds within TIMEOUT
// wait cycles, the transaction completes with err set and zero read data.
//
// Parameters
//   TIMEOUT         maximum number of wait cycles before a transaction aborts
//
// Ports
//   clk             clock; all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   rN_req          requester N request, held until rN_ack
//   rN_addr         requester N byte address
//   rN_wdata        requester N write data
//   rN_we           requester N write enable (1 = write, 0 = read)
//   rN_sign_mask    requester N access size/signedness, passed to memory
//   rN_ack          one-cycle completion pulse to requester N
//   rN_rdata        read result, zero unless rN_ack is high
//   rN_err          timeout flag, zero unless rN_ack is high
//   mem_addr        registered address of the granted request
//   mem_write_data  registered write data of the granted request
//   mem_sign_mask   registered sign mask of the granted request
//   mem_memread     one-cycle read command strobe
//   mem_memwrite    one-cycle write command strobe
//   mem_read_data   memory read result
//   mem_clk_stall   memory busy indication

module data_mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r0_we,
  input  logic [3:0]  r0_sign_mask,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_err,

  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic        r1_we,
  input  logic [3:0]  r1_sign_mask,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  // Counter must be able to hold the value TIMEOUT itself.
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStall,
    StWaitDone,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;      // 0 = r0, 1 = r1 for transaction in flight
  logic            last_q, last_d;    // last requester that completed
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sel;
  logic [CntW-1:0] cnt_inc;
  logic            timeout_hit;

  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (cnt_inc == CntW'(TIMEOUT));

  // Round-robin pick: a lone requester wins, a tie goes to the one not
  // served last.
  always_comb begin
    sel = 1'b0;
    if (r0_req && r1_req) begin
      sel = ~last_q;
    end else begin
      sel = r1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if ((r0_req || r1_req) && !mem_clk_stall) begin
          gnt_d   = sel;
          we_d    = sel ? r1_we        : r0_we;
          addr_d  = sel ? r1_addr      : r0_addr;
          wdata_d = sel ? r1_wdata     : r0_wdata;
          mask_d  = sel ? r1_sign_mask : r0_sign_mask;
          state_d = StIssue;
        end
      end

      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitStall;
      end

      StWaitStall: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (mem_clk_stall) begin
          state_d = StWaitDone;
        end
      end

      StWaitDone: begin
        cnt_d = cnt_inc;
        // Data arriving on the last permitted cycle still counts as success.
        if (!mem_clk_stall) begin
          rdata_d = we_q ? 32'h0 : mem_read_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        last_d  = gnt_q;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = (state_q == StIssue) && !we_q;
  assign mem_memwrite   = (state_q == StIssue) && we_q;

  assign r0_ack   = (state_q == StResp) && !gnt_q;
  assign r1_ack   = (state_q == StResp) && gnt_q;
  assign r0_rdata = r0_ack ? rdata_q : 32'h0;
  assign r1_rdata = r1_ack ? rdata_q : 32'h0;
  assign r0_err   = r0_ack && err_q;
  assign r1_err   = r1_ack && err_q;

endmodule
